// File: rtl/part_two_result_serializer.sv
// Captures partTwo results into a small FIFO and streams each byte MSB-first over valid/ready.
// Defining PART_TWO_PARITY_EN appends an even-parity bit to every frame.
module part_two_result_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         y,
    input  logic                     y_valid,
    output logic                     y_ready,
    output logic                     tx_data,
    output logic                     tx_valid,
    output logic                     tx_last,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PART_TWO_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [1:0]       state_q, state_d;
    logic             overflow_q, overflow_d;
    logic             tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
`ifdef PART_TWO_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             not_full;
    logic             push;
    logic             pop;

    // FIFO bookkeeping; readiness uses the pre-edge count so a full write is dropped even on a pop
    always_comb begin
        not_full   = (count_q != CNT_W'(DEPTH));
        push       = y_valid && not_full;
        pop        = (state_q == ST_IDLE) && (count_q != '0);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q || (y_valid && !not_full);
        if (push) begin
            mem_d[wr_ptr_q] = y;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Serializer FSM; tx outputs are registered from the next-state values
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
`ifdef PART_TWO_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    sh_d      = mem_q[rd_ptr_q];
                    bit_cnt_d = BIT_W'(WIDTH - 1);
                    state_d   = ST_SHIFT;
`ifdef PART_TWO_PARITY_EN
                    parity_d  = ^mem_q[rd_ptr_q];
`endif
                end
            end
            ST_SHIFT: begin
                if (tx_ready) begin
                    sh_d      = sh_q << 1;
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    if (bit_cnt_q == '0) begin
`ifdef PART_TWO_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PART_TWO_PARITY_EN
            ST_PARITY: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        tx_valid_d = (state_d != ST_IDLE);
`ifdef PART_TWO_PARITY_EN
        tx_data_d  = ((state_d == ST_SHIFT) && sh_d[WIDTH-1]) || ((state_d == ST_PARITY) && parity_d);
        tx_last_d  = (state_d == ST_PARITY);
`else
        tx_data_d  = (state_d == ST_SHIFT) && sh_d[WIDTH-1];
        tx_last_d  = (state_d == ST_SHIFT) && (bit_cnt_d == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
            tx_data_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
`ifdef PART_TWO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
`ifdef PART_TWO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage array carries no reset; only the pointers define occupancy
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign y_ready  = not_full;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: doc/part_two_result_serializer.md
# part_two_result_serializer

- Downstream stage of `partTwo`: captures its 8-bit combinational result `y` on a strobe and buffers it in a small FIFO.
- Drains each buffered byte MSB-first as a one-bit stream under a valid/ready handshake.
- Decouples the combinational transform from a slow serial consumer, so `x` can change every cycle without losing results.

## Interface
- `WIDTH`, default 8: data width of `y` and of each serial frame.
- `DEPTH`, default 4: number of FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `y`  in  WIDTH  result from `partTwo`.
- `y_valid`  in  1  capture strobe; `y` is sampled on the edge where it is high.
- `y_ready`  out  1  high when the FIFO is not full.
- `tx_data`  out  1  current serial bit.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_last`  out  1  marks the final bit of the current frame.
- `tx_ready`  in  1  consumer accepts the bit on this edge.
- `count`  out  log2(DEPTH)+1  number of FIFO entries occupied; excludes the byte held in the shifter.
- `overflow`  out  1  sticky flag: a write was dropped.

## Operation
- **FIFO write:** when `y_valid && y_ready`, `y` goes to `mem[wr_ptr]` and `wr_ptr` increments, wrapping modulo DEPTH.
- **Write while full:** `y_valid` with `y_ready`=0 drops the byte and sets `overflow`. `overflow` clears only on reset.
- **FSM states:** IDLE, SHIFT, and PARITY (PARITY exists only with the macro described under Configuration).
- **IDLE:**
  - `tx_valid`=0.
  - If `count`≠0: pop `mem[rd_ptr]` into the shift register `sh`, set `bit_cnt`=WIDTH-1, go to SHIFT.
- **SHIFT:**
  - `tx_valid`=1, `tx_data`=`sh[WIDTH-1]`, `tx_last`=(`bit_cnt`==0) and PARITY not enabled.
  - On `tx_ready`: shift `sh` left and decrement `bit_cnt`.
  - On `tx_ready` with `bit_cnt`==0: go to IDLE, or to PARITY when enabled.
- **Back-pressure:** while `tx_ready`=0, `tx_data`, `tx_valid` and `tx_last` hold stable.
- **Frame spacing:** frames are separated by at least one idle cycle, since IDLE always lasts one cycle.
- **Simultaneous push and pop:** both take effect and `count` is unchanged. `y_ready` is evaluated on the pre-edge `count`, so a write arriving while full is dropped even if a pop happens on the same edge.
- **Capacity:** DEPTH bytes in the FIFO plus one byte in the shifter.

## Timing
- **Reset values:** `tx_data`=0, `tx_valid`=0, `tx_last`=0, `y_ready`=1, `count`=0, `overflow`=0. Pointers, `sh` and `bit_cnt` are zero and the FSM is in IDLE.
- **Reset mid-frame:** the frame is abandoned and FIFO contents are discarded; outputs go to their reset values immediately (asynchronous).
- **Latency:**
  - Write at edge N → pop at edge N+1 → first bit valid after edge N+1.
  - With `tx_ready` held high, a frame occupies WIDTH cycles (WIDTH+1 with parity).
- **Outputs:** `tx_*` are driven from registered state only and do not depend combinationally on `tx_ready`. `y_ready` is combinational from `count`.

## Configuration
- **`PART_TWO_PARITY_EN` defined:**
  - After the last data bit, PARITY state drives `tx_valid`=1, `tx_data` = XOR of the byte (even parity), and `tx_last`=1.
  - Leaves PARITY for IDLE on `tx_ready`.
  - Parity is computed when the byte is popped and held until sent.
- **Not defined:** no PARITY state, and `tx_last` rides on data bit 0.

## Test plan
- **Single byte:** reset, `y`=8'hA2 with `y_valid` for 1 cycle, `tx_ready`=1.
  - Expect stream 1,0,1,0,0,0,1,0, with `tx_last` on the 8th bit and first bit valid one edge after capture.
  - With `PART_TWO_PARITY_EN`, a 9th bit of 1 follows with `tx_last`.
- **Back-to-back:** 8'hA2 then 8'h8E on consecutive cycles.
  - Expect both frames in order, one idle cycle between them, and `count` peaking at 1.
  - With the macro, the parity bit for 8'h8E is 0.
- **Back-pressure:** `tx_ready`=0 for 5 cycles during bit 3 of 8'hA2.
  - Expect `tx_data`=0 and `tx_valid`=1 held stable, and the stream resumes intact.
- **Full/overflow:** `tx_ready`=0, then 6 writes 8'h01..8'h06.
  - Expect 01 in the shifter, `count`=4, `y_ready`=0, byte 06 dropped and `overflow`=1.
  - Release `tx_ready`: expect 01–05 in order, and `overflow` still 1.
- **Wrap-around:** 12 sequential writes paced to avoid overflow.
  - Expect all 12 bytes out in order across pointer wrap, and `count` returns to 0.
- **Reset mid-frame:** assert `rst_n`=0 during bit 4 with 2 bytes queued.
  - Expect all outputs at reset values immediately, and no frames after release until a new write.
